// File: rtl/seven_seg_scanner.sv
// Multiplexed 4-digit seven-segment anode scanner.
// Blanks each slot briefly and swaps the digit mask only on frame boundaries.
module seven_seg_scanner #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] mask_in,
  input  logic       load,
  output logic       load_ack,
  output logic [2:0] cntr,
  output logic [3:0] anode,
  output logic       frame_done
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 2;
  localparam logic [PW-1:0] SLOT_LAST  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    ON
  } state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [3:0]    active_mask;
  logic [3:0]    pend_mask;
  logic          pend_valid;
  logic [3:0]    lit;
  logic          slot_end;
  logic          wrap;

  // Anode pattern for the current digit under the active mask.
  always_comb begin
    lit = 4'b1111;
    if (active_mask[cntr[1:0]])
      lit = ~(4'b0001 << cntr[1:0]);
  end

  assign slot_end = (presc == SLOT_LAST);
  assign wrap     = slot_end && (cntr[1:0] == 2'd3);

  // Scan sequencer, prescaler and mask handoff, all registered together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      presc       <= '0;
      cntr        <= 3'b000;
      anode       <= 4'b1111;
      frame_done  <= 1'b0;
      load_ack    <= 1'b0;
      active_mask <= 4'b1111;
      pend_mask   <= 4'b0000;
      pend_valid  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      load_ack   <= 1'b0;
      if (!en) begin
        state <= IDLE;
        presc <= '0;
        cntr  <= 3'b000;
        anode <= 4'b1111;
        if (pend_valid) begin
          active_mask <= pend_mask;
          load_ack    <= 1'b1;
          pend_valid  <= 1'b0;
        end
      end else begin
        unique case (state)
          IDLE: begin
            state <= BLANK;
            presc <= '0;
          end
          BLANK: begin
            presc <= presc + PW'(1);
            if (presc == BLANK_LAST) begin
              state <= ON;
              anode <= lit;
            end
          end
          ON: begin
            if (slot_end) begin
              presc <= '0;
              state <= BLANK;
              anode <= 4'b1111;
              cntr  <= {1'b0, cntr[1:0] + 2'd1};
              if (wrap) begin
                frame_done <= 1'b1;
                if (pend_valid) begin
                  active_mask <= pend_mask;
                  load_ack    <= 1'b1;
                  pend_valid  <= 1'b0;
                end
              end
            end else begin
              presc <= presc + PW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
      // A load sampled on the applying edge becomes the next pending mask.
      if (load) begin
        pend_mask  <= mask_in;
        pend_valid <= 1'b1;
      end
    end
  end

endmodule
